mmu_seq_ctrl: RTL and testbench

// - Sequencer for an N x N systolic matrix-multiply array built from MAC cells.
//   Per job: clears the accumulators, streams k_len operand columns from the operand

---
 rtl/mmu_seq_if.sv | 33 +++
 rtl/mmu_seq_ctrl.sv | 128 ++++++++++++
 tb/tb_mmu_seq_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_seq_if.sv
// Command, operand-feeder and array-control signals of the systolic MMU sequencer.
// The master side issues jobs and reports stalls; the slave side is the sequencer.
interface mmu_seq_if #(
  parameter int N   = 4,
  parameter int K_W = 8
);
  localparam int ROW_W = $clog2(N);

  logic             start;
  logic [K_W-1:0]   k_len;
  logic             stall;
  logic             busy;
  logic             done;
  logic             err;
  logic             op_rd_en;
  logic [K_W-1:0]   op_rd_idx;
  logic             arr_clear;
  logic             arr_shift;
  logic             res_valid;
  logic [ROW_W-1:0] res_row;

  modport master (
    output start, k_len, stall,
    input  busy, done, err, op_rd_en, op_rd_idx,
    input  arr_clear, arr_shift, res_valid, res_row
  );

  modport slave (
    input  start, k_len, stall,
    output busy, done, err, op_rd_en, op_rd_idx,
    output arr_clear, arr_shift, res_valid, res_row
  );
endinterface

// File: rtl/mmu_seq_ctrl.sv
// Job sequencer for an N x N systolic MAC array: clear, feed k_len operand columns,
// drain the skewed wavefront, then shift result rows out bottom row first.
module mmu_seq_ctrl #(
  parameter int N   = 4,
  parameter int K_W = 8,
  parameter int LAT = 2
) (
  input logic      clk,
  input logic      rst,
  mmu_seq_if.slave bus
);
  localparam int ROW_W     = $clog2(N);
  localparam int DRAIN_CYC = 2 * (N - 1) + LAT;
  localparam int DC_W      = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state;
  logic [K_W-1:0]   k_lat;
  logic [K_W-1:0]   feed_cnt;
  logic [DC_W-1:0]  drain_cnt;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             rd_en_q;
  logic [K_W-1:0]   rd_idx_q;
  logic             clear_q;
  logic             shift_q;
  logic [ROW_W-1:0] row_q;

  // The stall seen on the edge that launches a FEED cycle decides whether that
  // cycle carries a read; feed_cnt is the next column index still to be issued.
  // NOTE: every register here is written with <= so all state updates see the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      k_lat     <= '0;
      feed_cnt  <= '0;
      drain_cnt <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_idx_q  <= '0;
      clear_q   <= 1'b0;
      shift_q   <= 1'b0;
      row_q     <= '0;
    end else begin
      clear_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.k_len != '0) begin
              k_lat   <= bus.k_len;
              busy_q  <= 1'b1;
              clear_q <= 1'b1;
              state   <= S_CLEAR;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          state    <= S_FEED;
          rd_idx_q <= '0;
          rd_en_q  <= !bus.stall;
          feed_cnt <= bus.stall ? '0 : K_W'(1);
        end
        S_FEED: begin
          if (rd_en_q && rd_idx_q == k_lat - K_W'(1)) begin
            rd_en_q   <= 1'b0;
            drain_cnt <= DC_W'(DRAIN_CYC - 1);
            state     <= S_DRAIN;
          end else if (!bus.stall) begin
            rd_en_q  <= 1'b1;
            rd_idx_q <= feed_cnt;
            feed_cnt <= feed_cnt + K_W'(1);
          end else begin
            rd_en_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            shift_q <= 1'b1;
            row_q   <= ROW_W'(N - 1);
            state   <= S_SHIFT;
          end else begin
            drain_cnt <= drain_cnt - DC_W'(1);
          end
        end
        S_SHIFT: begin
          if (row_q == '0) begin
            shift_q <= 1'b0;
            done_q  <= 1'b1;
            state   <= S_DONE;
          end else begin
            row_q <= row_q - ROW_W'(1);
          end
        end
        S_DONE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.op_rd_en  = rd_en_q;
  assign bus.op_rd_idx = rd_idx_q;
  assign bus.arr_clear = clear_q;
  assign bus.arr_shift = shift_q;
  assign bus.res_valid = shift_q;
  assign bus.res_row   = row_q;
endmodule

// File: tb/tb_mmu_seq_ctrl.sv
// Scoreboard bench for mmu_seq_ctrl: a job-level model queues expected events per
// output, and a negedge monitor pops and compares them as the DUT presents them.
module tb_mmu_seq_ctrl;
  localparam int N    = 4;
  localparam int K_W  = 8;
  localparam int LAT  = 2;
  localparam int DRN  = 2 * (N - 1) + LAT;
  localparam int PLAN = 1024;

  typedef struct { int cyc; int val; } ev_t;
  typedef struct { int lo;  int hi;  } win_t;

  logic clk;
  logic rst;
  mmu_seq_if #(.N(N), .K_W(K_W)) ifc ();

  mmu_seq_ctrl #(.N(N), .K_W(K_W), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;

  ev_t  q_clear[$];
  ev_t  q_rd[$];
  ev_t  q_res[$];
  ev_t  q_done[$];
  ev_t  q_err[$];
  win_t q_busy[$];

  // Stall plan of the current job, indexed by edge offset from its accepting edge.
  bit   plan[PLAN];
  bit   forced[PLAN];
  bit   use_forced = 1'b0;
  int   stall_pct  = 0;
  int   job_base   = -100000;
  int   idle_from  = 0;
  int   shift_from = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // A job accepted on edge p: reads go out on later edges whose stall plan is
  // clear, then DRN quiet cycles, N result rows bottom-up, and one done cycle.
  task automatic plan_job(input int p, input int k);
    int e;
    int i;
    int last;
    for (int o = 0; o < PLAN; o++)
      plan[o] = use_forced ? forced[o]
                           : ((o < PLAN / 2) && ($urandom_range(0, 99) < stall_pct));
    q_clear.push_back('{p, 1});
    e = p + 1;
    i = 0;
    while (i < k) begin
      if (!plan[e - p]) begin
        q_rd.push_back('{e, i});
        i++;
      end
      e++;
    end
    last       = e - 1;
    shift_from = last + DRN + 1;
    for (int j = 0; j < N; j++) q_res.push_back('{shift_from + j, N - 1 - j});
    q_done.push_back('{shift_from + N, 1});
    q_busy.push_back('{p, shift_from + N});
    idle_from = shift_from + N + 2;
    job_base  = p;
  endtask

  task automatic model(input bit st, input logic [K_W-1:0] k, input bit r);
    if (r) begin
      q_clear.delete(); q_rd.delete(); q_res.delete();
      q_done.delete();  q_err.delete(); q_busy.delete();
      idle_from = cyc + 1;
      job_base  = -100000;
    end else if (st && cyc >= idle_from) begin
      if (k == '0) q_err.push_back('{cyc, 1});
      else         plan_job(cyc, int'(k));
    end
  endtask

  task automatic tick(input bit st, input logic [K_W-1:0] k, input bit r);
    int off;
    off = cyc + 1 - job_base;
    ifc.stall = (off >= 0 && off < PLAN) ? plan[off] : ($urandom_range(0, 3) == 0);
    ifc.start = st;
    ifc.k_len = k;
    rst       = r;
    @(posedge clk);
    cyc++;
    model(st, k, r);
    #1;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0);
  endtask

  task automatic wait_idle();
    while (cyc + 1 < idle_from) tick(1'b0, '0, 1'b0);
  endtask

  always @(negedge clk) begin
    bit e;
    if (mon_en) begin
      e = (q_clear.size() > 0 && q_clear[0].cyc == cyc);
      check("arr_clear", ifc.arr_clear, e);
      if (e) void'(q_clear.pop_front());

      e = (q_rd.size() > 0 && q_rd[0].cyc == cyc);
      check("op_rd_en", ifc.op_rd_en, e);
      if (e) begin
        check("op_rd_idx", ifc.op_rd_idx, q_rd[0].val);
        void'(q_rd.pop_front());
      end

      e = (q_res.size() > 0 && q_res[0].cyc == cyc);
      check("res_valid", ifc.res_valid, e);
      check("arr_shift", ifc.arr_shift, e);
      if (e) begin
        check("res_row", ifc.res_row, q_res[0].val);
        void'(q_res.pop_front());
      end

      e = (q_done.size() > 0 && q_done[0].cyc == cyc);
      check("done", ifc.done, e);
      if (e) void'(q_done.pop_front());

      e = (q_err.size() > 0 && q_err[0].cyc == cyc);
      check("err", ifc.err, e);
      if (e) void'(q_err.pop_front());

      e = (q_busy.size() > 0 && cyc >= q_busy[0].lo && cyc <= q_busy[0].hi);
      check("busy", ifc.busy, e);
      if (q_busy.size() > 0 && cyc >= q_busy[0].hi) void'(q_busy.pop_front());
    end
  end

  initial begin
    int rst_at;
    int n;
    ifc.start = 1'b0;
    ifc.k_len = '0;
    ifc.stall = 1'b0;
    rst       = 1'b1;

    tick(1'b0, '0, 1'b1);
    mon_en = 1'b1;
    tick(1'b0, '0, 1'b1);
    idle_ticks(2);

    // Plain k_len=3 job without stalls.
    stall_pct = 0;
    tick(1'b1, 8'd3, 1'b0);
    wait_idle();
    idle_ticks(2);

    // k_len=3 with stall on the 2nd and 3rd feed edges.
    for (int o = 0; o < PLAN; o++) forced[o] = 1'b0;
    forced[2]  = 1'b1;
    forced[3]  = 1'b1;
    use_forced = 1'b1;
    tick(1'b1, 8'd3, 1'b0);
    use_forced = 1'b0;
    wait_idle();
    idle_ticks(1);

    // Zero-length job is rejected with err.
    tick(1'b1, 8'd0, 1'b0);
    idle_ticks(2);

    // Starts during FEED and on the done cycle are ignored; the next one is taken.
    stall_pct = 20;
    tick(1'b1, 8'd5, 1'b0);
    tick(1'b0, '0, 1'b0);
    tick(1'b1, 8'd9, 1'b0);
    tick(1'b1, 8'd0, 1'b0);
    while (cyc + 1 < idle_from - 1) tick(1'b0, '0, 1'b0);
    tick(1'b1, 8'd7, 1'b0);
    tick(1'b1, 8'd2, 1'b0);
    wait_idle();
    idle_ticks(1);

    // Reset on the second SHIFT cycle, then a fresh job.
    tick(1'b1, 8'd4, 1'b0);
    while (cyc + 1 < shift_from + 2) tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b1);
    tick(1'b1, 8'd3, 1'b0);
    wait_idle();
    idle_ticks(1);

    // Longest job: every index 0..254 exactly once.
    stall_pct = 0;
    tick(1'b1, 8'd255, 1'b0);
    wait_idle();
    idle_ticks(1);

    // Randomised jobs with stalls, stray starts and occasional resets.
    for (int j = 0; j < 25; j++) begin
      stall_pct = $urandom_range(0, 30);
      if ($urandom_range(0, 9) == 0)      tick(1'b1, 8'd0, 1'b0);
      else if ($urandom_range(0, 9) == 0) tick(1'b1, 8'd255, 1'b0);
      else                                tick(1'b1, K_W'($urandom_range(1, 20)), 1'b0);
      rst_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 40) : -1;
      n = 0;
      while (cyc + 1 < idle_from) begin
        n++;
        if (n == rst_at) tick(1'b0, '0, 1'b1);
        else tick($urandom_range(0, 7) == 0, K_W'($urandom_range(0, 15)), 1'b0);
      end
      idle_ticks($urandom_range(0, 3));
    end

    wait_idle();
    idle_ticks(3);
    check("events_outstanding",
          q_clear.size() + q_rd.size() + q_res.size() + q_done.size() + q_err.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
